// File: rtl/axis_frame_gen.sv
// AXI-Stream test frame generator: emits frame_count frames of frame_len beats
// counting up from seed, with optional idle gaps and tuser marking of last beats.
module axis_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [LEN_WIDTH-1:0]  frame_count,
  input  logic [7:0]            gap_len,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  err_inject,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  frames_sent,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  input  logic                  output_axis_tready
);

  // state | meaning
  // IDLE  | waiting for an accepted start, tvalid low
  // SEND  | presenting beats of the current frame
  // GAP   | inter-frame idle, gap_cnt counts down to zero
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  cfg_len, cfg_count;
  logic [7:0]            cfg_gap;
  logic [DATA_WIDTH-1:0] cfg_seed;
  logic                  cfg_err;
  logic [LEN_WIDTH-1:0]  beat_cnt, beat_nxt, frames_nxt, frames_inc, beat_inc;
  logic [7:0]            gap_cnt, gap_nxt;
  logic [DATA_WIDTH-1:0] tdata_nxt;
  logic                  tvalid_nxt, tlast_nxt, tuser_nxt;
  logic                  start_ok, xfer, last_xfer, run_done, next_is_last;

  assign start_ok     = (state == IDLE) && start && (frame_len != '0) && (frame_count != '0);
  assign xfer         = output_axis_tvalid && output_axis_tready;
  assign last_xfer    = xfer && output_axis_tlast;
  assign frames_inc   = frames_sent + LEN_ONE;
  assign beat_inc     = beat_cnt + LEN_ONE;
  assign run_done     = last_xfer && (frames_inc == cfg_count);
  assign next_is_last = (beat_inc == (cfg_len - LEN_ONE));

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = SEND;
      SEND: begin
        if (last_xfer) begin
          if (run_done)           state_nxt = IDLE;
          else if (cfg_gap != '0) state_nxt = GAP;
        end
      end
      GAP:  if (gap_cnt == '0) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; holding is the default so a
  // stalled beat keeps tdata/tlast/tuser unchanged.
  always_comb begin
    tdata_nxt  = output_axis_tdata;
    tvalid_nxt = output_axis_tvalid;
    tlast_nxt  = output_axis_tlast;
    tuser_nxt  = output_axis_tuser;
    beat_nxt   = beat_cnt;
    gap_nxt    = gap_cnt;
    frames_nxt = frames_sent;
    case (state)
      IDLE: begin
        if (start_ok) begin
          frames_nxt = '0;
          beat_nxt   = '0;
          tdata_nxt  = seed;
          tvalid_nxt = 1'b1;
          tlast_nxt  = (frame_len == LEN_ONE);
          tuser_nxt  = err_inject && (frame_len == LEN_ONE);
        end
      end
      SEND: begin
        if (last_xfer) begin
          frames_nxt = frames_inc;
          beat_nxt   = '0;
          if (run_done || (cfg_gap != '0)) begin
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
            tuser_nxt  = 1'b0;
            gap_nxt    = cfg_gap - 8'd1;
          end else begin
            tdata_nxt = cfg_seed;
            tlast_nxt = (cfg_len == LEN_ONE);
            tuser_nxt = cfg_err && (cfg_len == LEN_ONE);
          end
        end else if (xfer) begin
          beat_nxt  = beat_inc;
          tdata_nxt = output_axis_tdata + DATA_ONE;
          tlast_nxt = next_is_last;
          tuser_nxt = cfg_err && next_is_last;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          beat_nxt   = '0;
          tdata_nxt  = cfg_seed;
          tvalid_nxt = 1'b1;
          tlast_nxt  = (cfg_len == LEN_ONE);
          tuser_nxt  = cfg_err && (cfg_len == LEN_ONE);
        end else begin
          gap_nxt = gap_cnt - 8'd1;
        end
      end
      default: tvalid_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      cfg_len            <= '0;
      cfg_count          <= '0;
      cfg_gap            <= '0;
      cfg_seed           <= '0;
      cfg_err            <= 1'b0;
      beat_cnt           <= '0;
      gap_cnt            <= '0;
      frames_sent        <= '0;
      busy               <= 1'b0;
      output_axis_tdata  <= '0;
      output_axis_tvalid <= 1'b0;
      output_axis_tlast  <= 1'b0;
      output_axis_tuser  <= 1'b0;
    end else begin
      if (start_ok) begin
        cfg_len   <= frame_len;
        cfg_count <= frame_count;
        cfg_gap   <= gap_len;
        cfg_seed  <= seed;
        cfg_err   <= err_inject;
      end
      beat_cnt           <= beat_nxt;
      gap_cnt            <= gap_nxt;
      frames_sent        <= frames_nxt;
      busy               <= (state_nxt != IDLE);
      output_axis_tdata  <= tdata_nxt;
      output_axis_tvalid <= tvalid_nxt;
      output_axis_tlast  <= tlast_nxt;
      output_axis_tuser  <= tuser_nxt;
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: expected beats are queued at start and
// popped on every observed transfer; stalls and gaps are checked cycle by cycle.
module tb_axis_frame_gen;

  logic        clk = 1'b0;
  logic        async_rst;
  logic        start;
  logic [15:0] frame_len, frame_count;
  logic [7:0]  gap_len;
  logic [7:0]  seed;
  logic        err_inject;
  logic        busy;
  logic [15:0] frames_sent;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser, tready;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    xfers  = 0;
  logic  stall_prev = 1'b0;
  beat_t prev_beat;

  axis_frame_gen #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk                (clk),
    .async_rst          (async_rst),
    .start              (start),
    .frame_len          (frame_len),
    .frame_count        (frame_count),
    .gap_len            (gap_len),
    .seed               (seed),
    .err_inject         (err_inject),
    .busy               (busy),
    .frames_sent        (frames_sent),
    .output_axis_tdata  (tdata),
    .output_axis_tvalid (tvalid),
    .output_axis_tlast  (tlast),
    .output_axis_tuser  (tuser),
    .output_axis_tready (tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive tready at the falling edge, then judge what the next
  // rising edge will do with the currently presented beat.
  task automatic cycle(input logic rdy);
    beat_t exp_b;
    @(negedge clk);
    start  = 1'b0;
    tready = rdy;
    if (stall_prev) begin
      check("stall_tvalid", tvalid, 1'b1);
      check("stall_tdata",  tdata,  prev_beat.data);
      check("stall_tlast",  tlast,  prev_beat.last);
      check("stall_tuser",  tuser,  prev_beat.user);
    end
    if (tvalid && tready) begin
      xfers++;
      if (sb.size() == 0) begin
        check("unexpected_beat", 1'b1, 1'b0);
      end else begin
        exp_b = sb.pop_front();
        check("beat_tdata", tdata, exp_b.data);
        check("beat_tlast", tlast, exp_b.last);
        check("beat_tuser", tuser, exp_b.user);
      end
    end
    stall_prev = tvalid && !tready;
    prev_beat  = '{data: tdata, last: tlast, user: tuser};
  endtask

  task automatic do_start(input int len, input int cnt, input int gap,
                          input logic [7:0] sd, input logic err, input bit accept);
    logic [7:0] d;
    frame_len   = 16'(len);
    frame_count = 16'(cnt);
    gap_len     = 8'(gap);
    seed        = sd;
    err_inject  = err;
    start       = 1'b1;
    if (accept) begin
      for (int f = 0; f < cnt; f++) begin
        for (int k = 0; k < len; k++) begin
          d = sd + 8'(k);
          sb.push_back('{data: d, last: (k == len - 1), user: err && (k == len - 1)});
        end
      end
    end
  endtask

  task automatic run_until_idle(input int budget, input bit random_ready);
    int n;
    n = 0;
    do begin
      cycle(random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end while ((busy || tvalid) && n < budget);
    check("run_bound", {30'd0, busy, tvalid}, 32'd0);
  endtask

  initial begin
    logic [8:0] vbits;
    int         x0;

    async_rst = 1'b1; start = 1'b0; tready = 1'b0;
    frame_len = '0; frame_count = '0; gap_len = '0; seed = '0; err_inject = 1'b0;
    repeat (2) cycle(1'b0);
    check("rst_busy",   busy, 1'b0);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast",  tlast, 1'b0);
    check("rst_tuser",  tuser, 1'b0);
    check("rst_tdata",  tdata, 8'h00);
    check("rst_frames", frames_sent, 16'd0);

    // Single 4-beat frame, start on the first edge after reset release.
    async_rst = 1'b0;
    do_start(4, 1, 0, 8'h10, 1'b0, 1'b1);
    x0 = xfers;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1);
      check("t1_tvalid", tvalid, 1'b1);
    end
    check("t1_xfers", xfers - x0, 4);
    cycle(1'b1);
    check("t1_busy_fall", busy, 1'b0);
    check("t1_tvalid_low", tvalid, 1'b0);
    check("t1_frames", frames_sent, 16'd1);

    // Two 3-beat frames separated by a 2-cycle gap.
    do_start(3, 2, 2, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1);
      vbits[i] = tvalid;
    end
    check("t2_valid_pattern", vbits, 9'b011100111);
    check("t2_frames", frames_sent, 16'd2);
    check("t2_busy", busy, 1'b0);

    // Random backpressure over two 5-beat frames.
    cycle(1'b1);
    x0 = xfers;
    do_start(5, 2, 1, 8'hA0, 1'b0, 1'b1);
    run_until_idle(300, 1'b1);
    check("t3_xfers", xfers - x0, 10);
    check("t3_frames", frames_sent, 16'd2);
    check("t3_sb_empty", sb.size(), 0);

    // One-beat frames back to back with error marking.
    cycle(1'b1);
    x0 = xfers;
    do_start(1, 3, 0, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      check("t4_tvalid", tvalid, 1'b1);
    end
    check("t4_xfers", xfers - x0, 3);
    cycle(1'b1);
    check("t4_idle", tvalid, 1'b0);
    check("t4_frames", frames_sent, 16'd3);

    // Ignored starts: zero length while idle, then any start while busy.
    do_start(0, 1, 0, 8'h55, 1'b0, 1'b0);
    cycle(1'b1);
    check("t5_len0_busy", busy, 1'b0);
    check("t5_len0_tvalid", tvalid, 1'b0);
    check("t5_len0_frames", frames_sent, 16'd3);
    do_start(4, 1, 0, 8'h20, 1'b0, 1'b1);
    cycle(1'b1);
    cycle(1'b1);
    do_start(2, 5, 0, 8'h55, 1'b1, 1'b0);
    run_until_idle(20, 1'b0);
    cycle(1'b1);
    cycle(1'b1);
    check("t5_busy_after", busy, 1'b0);
    check("t5_tvalid_after", tvalid, 1'b0);
    check("t5_frames", frames_sent, 16'd1);
    check("t5_sb_empty", sb.size(), 0);

    // Reset asserted while beat 2 of the second frame is presented.
    do_start(6, 2, 0, 8'h30, 1'b0, 1'b1);
    repeat (8) cycle(1'b1);
    @(posedge clk);
    #1;
    check("t6_pre_tdata", tdata, 8'h32);
    check("t6_pre_frames", frames_sent, 16'd1);
    async_rst = 1'b1;
    #1;
    check("t6_rst_tvalid", tvalid, 1'b0);
    check("t6_rst_frames", frames_sent, 16'd0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_tdata", tdata, 8'h00);
    sb.delete();
    stall_prev = 1'b0;
    cycle(1'b1);
    cycle(1'b1);
    async_rst = 1'b0;
    do_start(3, 1, 0, 8'h30, 1'b0, 1'b1);
    cycle(1'b1);
    check("t6_restart_busy", busy, 1'b1);
    run_until_idle(20, 1'b0);
    check("t6_frames", frames_sent, 16'd1);
    check("t6_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_frame_gen.md
AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of output_axis_tdata and seed.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16: width of frame_len, frame_count and frames_sent.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port async_rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: single-cycle request to begin a run.
REQ-006 The block SHALL have port frame_len, input, LEN_WIDTH: beats per frame, sampled on accepted start.
REQ-007 The block SHALL have port frame_count, input, LEN_WIDTH: frames per run, sampled on accepted start.
REQ-008 The block SHALL have port gap_len, input, 8: idle cycles between frames, sampled on accepted start.
REQ-009 The block SHALL have port seed, input, DATA_WIDTH: first data value of each frame, sampled on accepted start.
REQ-010 The block SHALL have port err_inject, input, 1: when sampled high on start, tuser is set on every frame's last beat.
REQ-011 The block SHALL have port busy, output, 1: high while state is not IDLE.
REQ-012 The block SHALL have port frames_sent, output, LEN_WIDTH: count of completed frames in the current or last run.
REQ-013 The block SHALL have ports output_axis_tdata (DATA_WIDTH), output_axis_tvalid, output_axis_tlast and output_axis_tuser as outputs, and output_axis_tready as an input.

Function
REQ-014 The block SHALL implement states IDLE, SEND and GAP; every output SHALL be driven from a register.
REQ-015 A start is accepted only in IDLE with frame_len != 0 and frame_count != 0; otherwise it is ignored with no state change.
REQ-016 An accepted start SHALL latch the configuration, clear frames_sent and the beat counter, and enter SEND, with tvalid high on the next cycle.
REQ-017 A transfer SHALL occur when tvalid && tready are both high in the same cycle.
REQ-018 While tvalid is high and tready is low, tdata, tlast and tuser SHALL hold unchanged.
REQ-019 Beat k of each frame (k = 0 .. frame_len-1) SHALL carry tdata = seed + k mod 2^DATA_WIDTH, so each frame restarts at seed.
REQ-020 tlast SHALL be high only on beat k = frame_len-1; frame_len = 1 gives tlast on every beat.
REQ-021 tuser SHALL equal the latched err_inject on the tlast beat and be 0 on all other beats.
REQ-022 On a last-beat transfer, frames_sent SHALL increment by 1 in the same clock edge.
REQ-023 After a last-beat transfer, if frames_sent+1 == frame_count, the state SHALL go to IDLE with tvalid low on the next cycle.
REQ-024 After a last-beat transfer, if frames remain and gap_len == 0, the state SHALL stay in SEND, tvalid SHALL remain high, and the next cycle presents beat 0 of the next frame.
REQ-025 After a last-beat transfer, if frames remain and gap_len != 0, the state SHALL go to GAP with tvalid low for exactly gap_len cycles, then return to SEND.
REQ-026 tvalid SHALL be low in IDLE and GAP; start asserted while busy SHALL be ignored.
REQ-027 The beat counter SHALL be LEN_WIDTH bits and never wrap within a frame; frame_len = 2^LEN_WIDTH-1 SHALL be supported.
REQ-028 Inputs frame_len, frame_count, gap_len, seed and err_inject changing mid-run SHALL have no effect until the next accepted start.

Reset
REQ-029 async_rst high SHALL immediately force state IDLE and drive busy=0, tvalid=0, tlast=0, tuser=0, tdata=0 and frames_sent=0, including mid-frame.
REQ-030 After async_rst deasserts, the block SHALL accept a start on the first subsequent rising edge.

Verification
REQ-031 The bench SHALL check: frame_len=4, count=1, gap=0, seed=8'h10, tready=1, start -> tdata 10,11,12,13 on 4 consecutive cycles, tlast on 13, busy falls after, frames_sent=1.
REQ-032 The bench SHALL check: frame_len=3, count=2, gap=2, seed=0 -> beats 0,1,2, then 2 cycles with tvalid low, then 0,1,2, frames_sent=2.
REQ-033 The bench SHALL check: frame_len=5 with random tready backpressure -> tdata/tlast stable during every stall, exactly 5 transfers per frame, data sequence intact.
REQ-034 The bench SHALL check: frame_len=1, count=3, gap=0, err_inject=1, seed=8'hFF -> 3 back-to-back beats of FF, each with tlast=1 and tuser=1.
REQ-035 The bench SHALL check: start with frame_len=0, and start while busy -> both ignored, no change to busy or the output stream.
REQ-036 The bench SHALL check: async_rst asserted mid-frame (beat 2 of 6) -> tvalid=0 and frames_sent=0 before the next clock edge; a new start after release begins again at seed.
